// File: rtl/sensor_spi_pkg.sv
// Shared definitions for the 16-bit CMV300-style SPI register protocol
// (responder and master sides).
package sensor_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA_WR,
        ST_DATA_RD,
        ST_DONE
    } spi_state_e;

    localparam int   FRAME_BITS = 16;
    localparam int   CMD_BITS   = 8;
    localparam int   RW_BIT     = 15;
    localparam logic RW_WRITE   = 1'b1;

    // R/W flag taken from the command byte (upper half of the frame).
    function automatic logic cmd_rw(input logic [CMD_BITS-1:0] cmd);
        return cmd[RW_BIT-CMD_BITS];
    endfunction

endpackage

// File: rtl/sensor_spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, with one-cycle rise/fall
// pulses derived from the last two synchronized samples.
module sensor_spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk0,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/sensor_spi_responder.sv
// Sensor-side SPI responder: oversamples the SPI pins in clk0, decodes
// 16-bit R/W frames and drives a simple register-port handshake.
module sensor_spi_responder
    import sensor_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk0,
    input  logic             reset_n,
    input  logic             pin_spi_clk,
    input  logic             pin_spi_en,
    input  logic             pin_spi_in,
    input  logic             pin_spi_reset,
    output logic             pin_spi_out,
    output logic             pin_spi_out_oe,
    output logic [6:0]       reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic [7:0]       reg_rdata,
    output logic             frame_busy,
    output logic [ERR_W-1:0] err_cnt
);

    logic clk_q, clk_rise, clk_fall;
    logic en_q, en_rise, en_fall;
    logic in_q, in_rise, in_fall;
    logic unused_edges;

    sensor_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk0(clk0), .reset_n(reset_n), .d(pin_spi_clk),
        .q(clk_q), .rise(clk_rise), .fall(clk_fall)
    );
    sensor_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk0(clk0), .reset_n(reset_n), .d(pin_spi_en),
        .q(en_q), .rise(en_rise), .fall(en_fall)
    );
    sensor_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_in (
        .clk0(clk0), .reset_n(reset_n), .d(pin_spi_in),
        .q(in_q), .rise(in_rise), .fall(in_fall)
    );

    assign unused_edges = ^{clk_q, en_fall, in_rise, in_fall};

    spi_state_e            state, state_n;
    logic [4:0]            bit_cnt;
    logic [CMD_BITS-1:0]   sr, cmd_word;
    logic [7:0]            tx, rd_src;
    logic [RD_LATENCY:1]   rd_pipe;
    logic [SYNC_STAGES:0]  prime;
    logic                  armed;
    logic                  in_frame, cmd_end, frame_end, abort;
    logic                  cmd_latch, re_set, we_set, err_inc, miso_shift;

    assign cmd_word  = {sr[CMD_BITS-2:0], in_q};
    assign in_frame  = (state == ST_CMD) || (state == ST_DATA_WR) || (state == ST_DATA_RD);
    assign cmd_end   = clk_rise && (bit_cnt == 5'(CMD_BITS-1));
    assign frame_end = clk_rise && (bit_cnt == 5'(FRAME_BITS-1));
    // An enable drop coinciding with the last rise still counts as a full frame.
    assign abort     = in_frame && !en_q && !frame_end;
    assign rd_src    = rd_pipe[RD_LATENCY] ? reg_rdata : tx;

    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!pin_spi_reset) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (en_rise && armed) state_n = ST_CMD;
                ST_CMD: begin
                    if (abort)        state_n = ST_IDLE;
                    else if (cmd_end) state_n = (cmd_rw(cmd_word) == RW_WRITE) ? ST_DATA_WR : ST_DATA_RD;
                end
                ST_DATA_WR,
                ST_DATA_RD: begin
                    if (abort)          state_n = ST_IDLE;
                    else if (frame_end) state_n = ST_DONE;
                end
                ST_DONE:    if (!en_q) state_n = ST_IDLE;
                default:    state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_busy = (state != ST_IDLE);
        cmd_latch  = 1'b0;
        re_set     = 1'b0;
        we_set     = 1'b0;
        err_inc    = 1'b0;
        miso_shift = 1'b0;
        if (pin_spi_reset) begin
            err_inc    = abort;
            cmd_latch  = (state == ST_CMD) && cmd_end && !abort;
            re_set     = cmd_latch && (cmd_rw(cmd_word) != RW_WRITE);
            we_set     = (state == ST_DATA_WR) && frame_end;
            miso_shift = (state == ST_DATA_RD) && clk_fall;
        end
    end

    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt        <= '0;
            sr             <= '0;
            tx             <= '0;
            rd_pipe        <= '0;
            prime          <= '0;
            armed          <= 1'b0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_we         <= 1'b0;
            reg_re         <= 1'b0;
            err_cnt        <= '0;
            pin_spi_out    <= 1'b0;
            pin_spi_out_oe <= 1'b0;
        end else begin
            // Enable must be seen low once the synchronizer holds real samples,
            // so a frame already in flight at reset release is skipped.
            prime <= {prime[SYNC_STAGES-1:0], 1'b1};
            if (prime[SYNC_STAGES] && !en_q) armed <= 1'b1;

            if (state == ST_IDLE)           bit_cnt <= '0;
            else if (clk_rise && in_frame)  bit_cnt <= bit_cnt + 5'd1;
            if (clk_rise && in_frame)       sr <= cmd_word;

            reg_re <= re_set;
            reg_we <= we_set;
            if (cmd_latch) reg_addr  <= cmd_word[CMD_BITS-2:0];
            if (we_set)    reg_wdata <= cmd_word;
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);

            rd_pipe[1] <= reg_re;
            for (int i = 2; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];

            // Read data may land in the same cycle as the first fall; rd_src bypasses it.
            if (state_n == ST_IDLE) begin
                pin_spi_out    <= 1'b0;
                pin_spi_out_oe <= 1'b0;
            end else if (miso_shift) begin
                pin_spi_out    <= rd_src[7];
                pin_spi_out_oe <= 1'b1;
                tx             <= {rd_src[6:0], 1'b0};
            end else if (rd_pipe[RD_LATENCY]) begin
                tx <= reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sensor_spi_responder.sv
// Scoreboard bench: two responders (read latency 1 and 3) share the SPI pins.
module tb_sensor_spi_responder;

    logic clk0 = 1'b0;
    logic reset_n = 1'b1;
    logic spi_clk = 1'b0, spi_en = 1'b0, spi_in = 1'b0, spi_rst_n = 1'b1;

    logic       miso1, oe1, we1, re1, busy1;
    logic [6:0] addr1;
    logic [7:0] wdata1, rdata1, err1;
    logic       miso3, oe3, we3, re3, busy3;
    logic [6:0] addr3;
    logic [7:0] wdata3, rdata3, err3;

    int checks = 0;
    int failures = 0;
    int err_exp = 0;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t sb1[$];
    ev_t sb3[$];

    logic [7:0] mem [0:127];
    logic [7:0] p1, q1, q2, q3;

    always #5 clk0 = ~clk0;

    sensor_spi_responder #(.SYNC_STAGES(2), .RD_LATENCY(1), .ERR_W(8)) dut1 (
        .clk0(clk0), .reset_n(reset_n), .pin_spi_clk(spi_clk), .pin_spi_en(spi_en),
        .pin_spi_in(spi_in), .pin_spi_reset(spi_rst_n), .pin_spi_out(miso1),
        .pin_spi_out_oe(oe1), .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1),
        .reg_re(re1), .reg_rdata(rdata1), .frame_busy(busy1), .err_cnt(err1)
    );
    sensor_spi_responder #(.SYNC_STAGES(2), .RD_LATENCY(3), .ERR_W(8)) dut3 (
        .clk0(clk0), .reset_n(reset_n), .pin_spi_clk(spi_clk), .pin_spi_en(spi_en),
        .pin_spi_in(spi_in), .pin_spi_reset(spi_rst_n), .pin_spi_out(miso3),
        .pin_spi_out_oe(oe3), .reg_addr(addr3), .reg_wdata(wdata3), .reg_we(we3),
        .reg_re(re3), .reg_rdata(rdata3), .frame_busy(busy3), .err_cnt(err3)
    );

    // Register-port model: data valid only in the cycle RD_LATENCY after reg_re, noise otherwise.
    always @(posedge clk0) begin
        p1 <= re1 ? mem[addr1] : 8'($urandom);
        q1 <= re3 ? mem[addr3] : 8'($urandom);
        q2 <= q1;
        q3 <= q2;
    end
    assign rdata1 = p1;
    assign rdata3 = q3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    ev_t e1, e3;
    always @(negedge clk0) begin
        if (reset_n && (we1 || re1)) begin
            if (sb1.size() == 0) check("dut1_unexpected_strobe", 32'({we1, re1}), 32'd0);
            else begin
                e1 = sb1.pop_front();
                check("dut1_strobe", 32'({we1, re1, addr1, (we1 ? wdata1 : 8'h00)}),
                      32'({e1.we, ~e1.we, e1.addr, e1.data}));
            end
        end
    end
    always @(negedge clk0) begin
        if (reset_n && (we3 || re3)) begin
            if (sb3.size() == 0) check("dut3_unexpected_strobe", 32'({we3, re3}), 32'd0);
            else begin
                e3 = sb3.pop_front();
                check("dut3_strobe", 32'({we3, re3, addr3, (we3 ? wdata3 : 8'h00)}),
                      32'({e3.we, ~e3.we, e3.addr, e3.data}));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_err1"}, 32'(err1), 32'(err_exp));
        check({tag, "_err3"}, 32'(err3), 32'(err_exp));
        check({tag, "_idle_pins"}, 32'({busy1, oe1, miso1, busy3, oe3, miso3}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dut1"}, 32'({miso1, oe1, we1, re1, busy1, addr1, wdata1, err1}), 32'd0);
        check({tag, "_dut3"}, 32'({miso3, oe3, we3, re3, busy3, addr3, wdata3, err3}), 32'd0);
    endtask

    // act_kind: 0 none, 1 reset_n at rise act_at, 2 pin_spi_reset at rise act_at,
    // 3 enable dropped together with the 16th rise.
    task automatic frame(input logic [15:0] w, input int nrises, input int act_at, input int act_kind);
        logic       is_wr, exp_oe, exp_bit;
        logic [6:0] a;
        logic [7:0] rd;
        int         eff;
        bit         complete;
        is_wr    = w[15];
        a        = w[14:8];
        rd       = mem[a];
        eff      = (act_kind == 1 || act_kind == 2) ? act_at - 1 : nrises;
        complete = (act_kind == 0 || act_kind == 3) && nrises >= 16;
        if (!is_wr && eff >= 8) begin
            sb1.push_back('{1'b0, a, 8'h00});
            sb3.push_back('{1'b0, a, 8'h00});
        end
        if (is_wr && complete) begin
            sb1.push_back('{1'b1, a, w[7:0]});
            sb3.push_back('{1'b1, a, w[7:0]});
        end
        if (act_kind == 0 && nrises < 16 && err_exp != 255) err_exp++;

        @(negedge clk0);
        spi_en = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge clk0);
        for (int k = 1; k <= nrises; k++) begin
            spi_in = (k <= 16) ? w[16-k] : 1'b0;
            repeat (4) @(negedge clk0);
            if (k <= 16) begin
                exp_oe  = !is_wr && k >= 9;
                exp_bit = exp_oe ? rd[16-k] : 1'b0;
                check("dut1_miso", 32'({oe1, miso1}), 32'({exp_oe, exp_bit}));
                check("dut3_miso", 32'({oe3, miso3}), 32'({exp_oe, exp_bit}));
            end
            spi_clk = 1'b1;
            if (act_kind == 3 && k == 16) spi_en = 1'b0;
            if (act_kind == 1 && k == act_at) begin
                reset_n = 1'b0;
                err_exp = 0;
                #1;
                check_all_zero("async_reset");
                repeat (3) @(negedge clk0);
                spi_en = 1'b0;
                spi_clk = 1'b0;
                spi_in = 1'b0;
                reset_n = 1'b1;
                break;
            end
            if (act_kind == 2 && k == act_at) begin
                spi_rst_n = 1'b0;
                repeat (2) @(negedge clk0);
                check("spi_reset_busy", 32'({busy1, busy3, oe1, oe3}), 32'd0);
                spi_rst_n = 1'b1;
                repeat (2) @(negedge clk0);
            end else begin
                repeat (4) @(negedge clk0);
            end
            spi_clk = 1'b0;
        end
        repeat (2) @(negedge clk0);
        spi_en = 1'b0;
        repeat (8) @(negedge clk0);
        check_idle("frame_end");
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          nr;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h11] = 8'hA7;

        // Enable already high across reset release: that frame must be ignored.
        spi_en = 1'b1;
        #2 reset_n = 1'b0;
        #3;
        check_all_zero("reset_state");
        repeat (4) @(negedge clk0);
        reset_n = 1'b1;
        w = 16'h8A5C;
        for (int k = 1; k <= 16; k++) begin
            spi_in = w[16-k];
            repeat (4) @(negedge clk0);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk0);
            spi_clk = 1'b0;
        end
        check("ghost_frame_busy", 32'({busy1, busy3}), 32'd0);
        spi_en = 1'b0;
        repeat (8) @(negedge clk0);
        check_idle("ghost");

        frame(16'h8A5C, 16, 0, 0);
        frame(16'h1100, 16, 0, 0);
        frame(16'h8A5C, 11, 0, 0);
        frame(16'hFF01, 20, 0, 0);
        frame(16'h8E77, 16, 16, 3);
        frame(16'h2200, 16, 16, 3);
        frame(16'h3300, 16, 12, 1);
        frame(16'h7F00, 16, 0, 0);
        frame(16'h8C44, 16, 5, 2);
        frame(16'h8133, 16, 0, 0);

        for (int i = 0; i < 24; i++) begin
            w  = 16'($urandom);
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 20));
            frame(w, nr, 0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            w = {1'b1, 15'($urandom)};
            frame(w, int'($urandom_range(1, 15)), 0, 0);
        end
        check("err_saturated", 32'({err1, err3}), 32'hFFFF);

        check("sb1_leftover", 32'(sb1.size()), 32'd0);
        check("sb3_leftover", 32'(sb3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
